mcdf_arbiter_n: RTL and testbench

Parametrised N-channel arbiter between the slave FIFOs and the formatter in the MCDF datapath. It selects one requesting channel by programmable priority, with round-robin among equal priorities. It then forwards exactly one packet of the latched length from that channel to the formatter, with per-beat acknowledge back to the FIFO. It generalises the fixed 3-channel arbiter with: channel count and width parameters, fair tie-breaking, a per-channel enable mask and an end-of-packet flag.

---
 rtl/mcdf_arbiter_n_if.sv | 36 +++
 rtl/mcdf_arbiter_n.sv | 122 ++++++++++++
 tb/tb_mcdf_arbiter_n.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcdf_arbiter_n_if.sv
// Arbiter-side bundle for mcdf_arbiter_n: slave FIFO request/data lanes plus formatter handshake.
// master = arbiter, slave = FIFOs/formatter side.
interface mcdf_arbiter_n_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned PRIO_W = 2,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned IDW    = $clog2(NCH)
);
    logic [NCH*PRIO_W-1:0] slv_prio_i;
    logic [NCH*LEN_W-1:0]  slv_pkglen_i;
    logic [NCH-1:0]        slv_en_i;
    logic [NCH-1:0]        slv_req_i;
    logic [NCH-1:0]        slv_valid_i;
    logic [NCH*DW-1:0]     slv_data_i;
    logic                  f2a_id_req_i;
    logic                  f2a_ack_i;
    logic [NCH-1:0]        a2s_ack_o;
    logic                  a2f_valid_o;
    logic [IDW-1:0]        a2f_id_o;
    logic [LEN_W-1:0]      a2f_pkglen_sel_o;
    logic [DW-1:0]         a2f_data_o;
    logic                  a2f_last_o;

    modport master (
        input  slv_prio_i, slv_pkglen_i, slv_en_i, slv_req_i, slv_valid_i, slv_data_i,
        input  f2a_id_req_i, f2a_ack_i,
        output a2s_ack_o, a2f_valid_o, a2f_id_o, a2f_pkglen_sel_o, a2f_data_o, a2f_last_o
    );

    modport slave (
        output slv_prio_i, slv_pkglen_i, slv_en_i, slv_req_i, slv_valid_i, slv_data_i,
        output f2a_id_req_i, f2a_ack_i,
        input  a2s_ack_o, a2f_valid_o, a2f_id_o, a2f_pkglen_sel_o, a2f_data_o, a2f_last_o
    );
endinterface

// File: rtl/mcdf_arbiter_n.sv
// N-channel MCDF arbiter: priority grant with round-robin tie-break, then forwards one packet
// of the latched length from the granted FIFO to the formatter.
module mcdf_arbiter_n #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned PRIO_W = 2,
    parameter int unsigned LEN_W  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mcdf_arbiter_n_if.master bus
);
    localparam int unsigned IDW = $clog2(NCH);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0] code_q, code_d;
    logic [6:0]       len_q, len_d;
    logic [6:0]       cnt_q, cnt_d;

    logic [NCH-1:0]    elig;
    logic              found;
    logic [PRIO_W-1:0] best_prio;
    logic [IDW-1:0]    best_id;
    logic [LEN_W-1:0]  win_code;
    logic [6:0]        win_len;
    logic              valid, beat, last;

    assign elig = bus.slv_req_i & bus.slv_en_i;

    // Scan upward from rr_ptr; strict '<' keeps the first tied channel in scan order.
    always_comb begin
        int unsigned j;
        logic [IDW-1:0] cand;
        found     = 1'b0;
        best_prio = '0;
        best_id   = '0;
        j         = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            j = 32'(rr_ptr_q) + i;
            if (j >= NCH) j = j - NCH;
            cand = j[IDW-1:0];
            if (elig[cand] && (!found || bus.slv_prio_i[j*PRIO_W +: PRIO_W] < best_prio)) begin
                found     = 1'b1;
                best_prio = bus.slv_prio_i[j*PRIO_W +: PRIO_W];
                best_id   = cand;
            end
        end
    end

    // Codes above 4 clamp to the 64-beat maximum.
    always_comb begin
        win_code = bus.slv_pkglen_i[32'(best_id)*LEN_W +: LEN_W];
        if (32'(win_code) >= 4) win_len = 7'd64;
        else                    win_len = 7'd4 << win_code[1:0];
    end

    assign valid = (state_q == StXfer) && bus.slv_valid_i[id_q];
    assign beat  = valid && bus.f2a_ack_i;
    assign last  = valid && (cnt_q == len_q - 7'd1);

    always_comb begin
        bus.a2s_ack_o       = '0;
        bus.a2s_ack_o[id_q] = beat;
    end

    assign bus.a2f_valid_o      = valid;
    assign bus.a2f_last_o       = last;
    assign bus.a2f_id_o         = id_q;
    assign bus.a2f_pkglen_sel_o = code_q;
    assign bus.a2f_data_o       = (state_q == StXfer) ? bus.slv_data_i[32'(id_q)*DW +: DW] : '0;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        code_d   = code_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.f2a_id_req_i && found) begin
                    state_d  = StXfer;
                    id_d     = best_id;
                    code_d   = win_code;
                    len_d    = win_len;
                    cnt_d    = '0;
                    rr_ptr_d = (32'(best_id) == NCH - 1) ? '0 : best_id + 1'b1;
                end
            end
            StXfer: begin
                if (beat) begin
                    cnt_d = cnt_q + 7'd1;
                    if (last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            id_q     <= '0;
            rr_ptr_q <= '0;
            code_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            code_q   <= code_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mcdf_arbiter_n.sv
// Bench for mcdf_arbiter_n: directed scenarios then randomized packets against a packet-level
// model (min priority, first tie from rr pointer, clamped length).
module tb_mcdf_arbiter_n;
    localparam int unsigned NCH    = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned PRIO_W = 2;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned IDW    = 2;

    logic clk_i;
    logic rst_i;
    int   n_cmp;
    int   n_bad;
    int   rr;
    int   gap;
    int   win;
    int   seq [NCH];

    mcdf_arbiter_n_if #(.NCH(NCH), .DW(DW), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) bus ();

    mcdf_arbiter_n #(.NCH(NCH), .DW(DW), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Each channel presents {channel, running word index} so order and routing are visible.
    always_comb begin
        for (int k = 0; k < NCH; k++) bus.slv_data_i[k*DW +: DW] = {8'(k), seq[k][23:0]};
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(bus.a2f_valid_o), 64'(0));
        chk({tag, "_last"}, 64'(bus.a2f_last_o), 64'(0));
        chk({tag, "_data"}, 64'(bus.a2f_data_o), 64'(0));
        chk({tag, "_ack"}, 64'(bus.a2s_ack_o), 64'(0));
        chk({tag, "_id"}, 64'(bus.a2f_id_o), 64'(0));
        chk({tag, "_pkglen"}, 64'(bus.a2f_pkglen_sel_o), 64'(0));
    endtask

    task automatic set_ch(input int k, input int prio, input int code);
        bus.slv_prio_i[k*PRIO_W +: PRIO_W] = PRIO_W'(prio);
        bus.slv_pkglen_i[k*LEN_W +: LEN_W] = LEN_W'(code);
    endtask

    function automatic int prio_of(input int k);
        return int'(bus.slv_prio_i[k*PRIO_W +: PRIO_W]);
    endfunction

    function automatic int code_of(input int k);
        return int'(bus.slv_pkglen_i[k*LEN_W +: LEN_W]);
    endfunction

    // Reference pick: lowest priority value wins, ties to first eligible at or after rr.
    function automatic int model_pick(input int ptr);
        int best;
        logic [NCH-1:0] el;
        el   = bus.slv_req_i & bus.slv_en_i;
        best = 1 << PRIO_W;
        for (int k = 0; k < NCH; k++) if (el[IDW'(k)] && prio_of(k) < best) best = prio_of(k);
        for (int i = 0; i < NCH; i++) begin
            if (el[IDW'((ptr + i) % NCH)] && prio_of((ptr + i) % NCH) == best)
                return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    task automatic do_reset();
        bus.slv_req_i = '0;
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle("reset");
        rr = 0;
    endtask

    // mode: 0 clean, 1 valid/ack stall at beat 5, 2 mid-packet prio/req change,
    //       3 reset at beat 10, 4 random stalls
    task automatic xfer(input int exp_id, input int exp_code, input int exp_idle, input int mode);
        int len, b, idle, stall_s, guard, start;
        bit got, dv, da;
        len  = 4 << ((exp_code > 4) ? 4 : exp_code);
        got  = 1'b0;
        idle = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk_i); #1;
            bus.slv_valid_i = '1;
            bus.f2a_ack_i   = 1'b1;
            @(negedge clk_i);
            if (bus.a2f_valid_o === 1'b1) got = 1'b1;
            else begin
                idle++;
                chk("idle_ack", 64'(bus.a2s_ack_o), 64'(0));
            end
        end
        chk("grant_seen", 64'(got), 64'(1));
        if (!got) return;
        rr = (exp_id + 1) % NCH;
        chk("gap", 64'(idle), 64'(exp_idle));
        start   = seq[exp_id];
        b       = 0;
        stall_s = 0;
        guard   = 0;
        dv      = 1'b1;
        da      = 1'b1;
        while (guard < 8 * len + 50) begin
            chk("valid", 64'(bus.a2f_valid_o), 64'(dv));
            chk("ack", 64'(bus.a2s_ack_o), (dv && da) ? (64'(1) << exp_id) : 64'(0));
            chk("last", 64'(bus.a2f_last_o), 64'(dv && b == len - 1));
            if (dv) chk("data", 64'(bus.a2f_data_o), 64'({8'(exp_id), 24'(start + b)}));
            chk("id", 64'(bus.a2f_id_o), 64'(exp_id));
            chk("pkglen", 64'(bus.a2f_pkglen_sel_o), 64'(exp_code));
            if (dv && da) begin
                seq[exp_id]++;
                b++;
                if (mode == 2 && b == 2) begin
                    bus.slv_prio_i[exp_id*PRIO_W +: PRIO_W] = PRIO_W'(3);
                    bus.slv_prio_i[3*PRIO_W +: PRIO_W]      = PRIO_W'(0);
                    bus.slv_req_i = bus.slv_req_i & ~(4'(1) << exp_id);
                end
                if (mode == 3 && b == 10) begin
                    @(posedge clk_i); #1;
                    rst_i         = 1'b1;
                    bus.f2a_ack_i = 1'b0;
                    @(negedge clk_i);
                    chk("rst_cycle_ack", 64'(bus.a2s_ack_o), 64'(0));
                    @(posedge clk_i); #1;
                    rst_i         = 1'b0;
                    bus.f2a_ack_i = 1'b1;
                    @(negedge clk_i);
                    chk_idle("rst_mid");
                    return;
                end
            end
            if (b == len) break;
            guard++;
            @(posedge clk_i); #1;
            dv = 1'b1;
            da = 1'b1;
            if (mode == 1 && b == 5 && stall_s < 3) begin
                if (stall_s == 0) dv = 1'b0;
                else              da = 1'b0;
                stall_s++;
            end else if (mode == 4) begin
                dv = ($urandom_range(0, 3) != 0);
                da = ($urandom_range(0, 3) != 0);
            end
            bus.slv_valid_i = dv ? 4'hf : ~(4'(1) << exp_id);
            bus.f2a_ack_i   = da;
            @(negedge clk_i);
        end
        chk("beats", 64'(b), 64'(len));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rr    = 0;
        for (int k = 0; k < NCH; k++) seq[k] = 0;
        rst_i            = 1'b1;
        bus.slv_prio_i   = '0;
        bus.slv_pkglen_i = '0;
        bus.slv_en_i     = '1;
        bus.slv_req_i    = '0;
        bus.slv_valid_i  = '1;
        bus.f2a_id_req_i = 1'b1;
        bus.f2a_ack_i    = 1'b1;
        do_reset();

        // Strict priority: ch0 (code 3, 32 beats), then ch1 (code 2, 16 beats)
        set_ch(0, 1, 3); set_ch(1, 1, 2); set_ch(2, 2, 1); set_ch(3, 3, 0);
        bus.slv_req_i = '1;
        xfer(0, 3, 0, 0);
        xfer(1, 2, 1, 0);

        // Round-robin among equal priorities
        do_reset();
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 0);
        bus.slv_req_i = '1;
        xfer(0, 0, 0, 0);
        xfer(1, 0, 1, 0);
        xfer(2, 0, 1, 0);
        xfer(3, 0, 1, 0);
        xfer(0, 0, 1, 0);

        // Back-pressure on an 8-beat packet
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 1);
        xfer(1, 1, 1, 1);

        // No preemption: ch2 granted, then reprioritised and dropped mid-packet
        set_ch(0, 3, 2); set_ch(1, 3, 2); set_ch(2, 1, 2); set_ch(3, 2, 2);
        xfer(2, 2, 1, 2);
        xfer(3, 2, 1, 0);

        // Enable mask and code clamp; ch0 has best prio but is disabled
        set_ch(0, 0, 0); set_ch(1, 1, 7); set_ch(2, 2, 0); set_ch(3, 1, 0);
        bus.slv_en_i  = 4'b1010;
        bus.slv_req_i = '1;
        xfer(1, 7, 1, 0);
        xfer(3, 0, 1, 0);
        bus.slv_req_i = 4'b0101;
        repeat (4) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("masked_valid", 64'(bus.a2f_valid_o), 64'(0));
            chk("masked_ack", 64'(bus.a2s_ack_o), 64'(0));
        end

        // Reset mid-packet, then equal priorities restart at ch0
        bus.slv_en_i  = '1;
        bus.slv_req_i = 4'b0110;
        for (int k = 0; k < NCH; k++) set_ch(k, 1, 2);
        xfer(1, 2, 0, 3);
        bus.slv_req_i = '1;
        xfer(0, 2, 0, 0);

        // Randomized packets against the reference pick
        gap = 1;
        for (int p = 0; p < 24; p++) begin
            for (int k = 0; k < NCH; k++) set_ch(k, $urandom_range(0, 3), $urandom_range(0, 7));
            bus.slv_en_i  = 4'($urandom);
            bus.slv_req_i = 4'($urandom);
            win = model_pick(rr);
            if (win < 0) begin
                repeat (3) begin
                    @(posedge clk_i); #1;
                    @(negedge clk_i);
                    chk("noelig_valid", 64'(bus.a2f_valid_o), 64'(0));
                    chk("noelig_ack", 64'(bus.a2s_ack_o), 64'(0));
                end
                gap = 0;
            end else begin
                xfer(win, code_of(win), gap, 4);
                gap = 1;
            end
        end

        bus.slv_req_i = '0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("tail_idle", 64'(bus.a2f_valid_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
